// File: rtl/dac_spi_arbiter.sv
// Round-robin arbiter sharing one 16-bit SPI DAC link between NUM_REQ requesters.
// Grants a word in IDLE, shifts it out MSB first, reports completion and pulses LDAC_N.
module dac_spi_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CLK_DIV = 1,
    parameter int T_CSH   = 2,
    parameter int LDAC_EN = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [16*NUM_REQ-1:0]   req_word,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    busy,
    output logic                    done,
    output logic [ID_W-1:0]         done_id,
    output logic                    CS,
    output logic                    SCLK,
    output logic                    SDO,
    output logic                    LDAC_N
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam logic [3:0] DIV_LAST  = 4'(CLK_DIV - 1);
    localparam logic [3:0] HOLD_LAST = 4'(T_CSH - 1);

    logic [1:0]      r_state;
    logic [3:0]      r_cnt;
    logic [3:0]      r_bits;
    logic [14:0]     r_shift;
    logic [ID_W-1:0] r_owner;
    logic [ID_W-1:0] r_last;
    logic            r_cs;
    logic            r_sclk;
    logic            r_sdo;
    logic            r_done;
    logic [ID_W-1:0] r_done_id;
    logic            r_ldac_n;

    logic            w_found;
    logic [ID_W-1:0] w_winner;
    logic            w_accept;
    logic [15:0]     w_word;

    // Search starts just after the last granted index, so the previous owner ranks lowest.
    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(r_last) + k) % NUM_REQ;
            if (!w_found && req_valid[idx]) begin
                w_found  = 1'b1;
                w_winner = ID_W'(idx);
            end
        end
    end

    assign w_accept  = (r_state == S_IDLE) && enable && w_found && !rst;
    assign w_word    = req_word[16*int'(w_winner) +: 16];
    assign req_ready = w_accept ? (NUM_REQ'(1) << w_winner) : '0;
    assign busy      = w_accept || (r_state != S_IDLE);

    assign CS      = r_cs;
    assign SCLK    = r_sclk;
    assign SDO     = r_sdo;
    assign done    = r_done;
    assign done_id = r_done_id;
    assign LDAC_N  = r_ldac_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bits    <= '0;
            r_shift   <= '0;
            r_owner   <= '0;
            r_last    <= ID_W'(NUM_REQ - 1);
            r_cs      <= 1'b1;
            r_sclk    <= 1'b0;
            r_sdo     <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= '0;
            r_ldac_n  <= 1'b1;
        end else begin
            // NOTE: non-blocking so every register sees pre-edge values of the others.
            r_done   <= 1'b0;
            r_ldac_n <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift <= w_word[14:0];
                        r_sdo   <= w_word[15];
                        r_owner <= w_winner;
                        r_last  <= w_winner;
                        r_cs    <= 1'b0;
                        r_bits  <= '0;
                        r_cnt   <= '0;
                        r_state <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (r_cnt == DIV_LAST) begin
                        r_cnt   <= '0;
                        r_sclk  <= 1'b1;
                        r_state <= S_HIGH;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_HIGH: begin
                    if (r_cnt == DIV_LAST) begin
                        r_cnt  <= '0;
                        r_sclk <= 1'b0;
                        if (r_bits != 4'd15) begin
                            // Next bit moves out on the falling edge, away from the DAC's sample edge.
                            r_sdo   <= r_shift[14];
                            r_shift <= {r_shift[13:0], 1'b0};
                            r_bits  <= r_bits + 4'd1;
                            r_state <= S_LOW;
                        end else begin
                            r_cs      <= 1'b1;
                            r_done    <= 1'b1;
                            r_done_id <= r_owner;
                            r_ldac_n  <= (LDAC_EN == 0);
                            r_state   <= S_HOLD;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_arbiter.sv
// Directed bench for dac_spi_arbiter: a CLK_DIV=1/LDAC_EN=1 instance for arbitration,
// framing, reset and enable, plus a CLK_DIV=3/LDAC_EN=0 instance for timing scaling.
module tb_dac_spi_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable, enable2;
    logic [3:0]  valid, valid2;
    logic [63:0] word, word2;
    logic        sel;

    logic [3:0]  rdy1, rdy2;
    logic        busy1, busy2, done1, done2;
    logic [1:0]  did1, did2;
    logic        cs1, cs2, sclk1, sclk2, sdo1, sdo2, ldn1, ldn2;

    logic [3:0]  m_rdy;
    logic        m_done, m_cs, m_sclk, m_sdo, m_ldn;
    logic [1:0]  m_did;

    int total = 0;
    int bad   = 0;
    int ld2_lows = 0;

    always #5 clk = ~clk;

    dac_spi_arbiter #(.NUM_REQ(4), .ID_W(2), .CLK_DIV(1), .T_CSH(2), .LDAC_EN(1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .req_valid(valid), .req_word(word),
        .req_ready(rdy1), .busy(busy1), .done(done1), .done_id(did1),
        .CS(cs1), .SCLK(sclk1), .SDO(sdo1), .LDAC_N(ldn1)
    );

    dac_spi_arbiter #(.NUM_REQ(4), .ID_W(2), .CLK_DIV(3), .T_CSH(2), .LDAC_EN(0)) dut2 (
        .clk(clk), .rst(rst), .enable(enable2), .req_valid(valid2), .req_word(word2),
        .req_ready(rdy2), .busy(busy2), .done(done2), .done_id(did2),
        .CS(cs2), .SCLK(sclk2), .SDO(sdo2), .LDAC_N(ldn2)
    );

    assign m_rdy  = sel ? rdy2  : rdy1;
    assign m_done = sel ? done2 : done1;
    assign m_did  = sel ? did2  : did1;
    assign m_cs   = sel ? cs2   : cs1;
    assign m_sclk = sel ? sclk2 : sclk1;
    assign m_sdo  = sel ? sdo2  : sdo1;
    assign m_ldn  = sel ? ldn2  : ldn1;

    always @(negedge clk) if (ldn2 !== 1'b1) ld2_lows++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called on a negedge; returns on the first negedge after CS rises.
    task automatic capture(output logic [15:0] w, output int cs_len, output int period);
        int budget = 0;
        int rises = 0;
        int first_rise = 0;
        logic prev;
        w = '0; cs_len = 0; period = 0;
        while (m_cs !== 1'b0 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check("cs_fall_wait", 32'(budget < 100), 1);
        prev = m_sclk;
        while (m_cs === 1'b0 && cs_len < 600) begin
            if (m_sclk && !prev) begin
                w = {w[14:0], m_sdo};
                rises++;
                if (rises == 1) first_rise = cs_len;
                else if (rises == 2) period = cs_len - first_rise;
            end
            prev = m_sclk;
            cs_len++;
            @(negedge clk);
        end
    endtask

    // Observes the CS-high interval until CS falls again or the bound expires.
    task automatic gap(input int bound, output int len, output logic [3:0] rdy,
                       output int rdy_cycles, output int done_cyc, output int ldl);
        len = 0; rdy = '0; rdy_cycles = 0; done_cyc = 0; ldl = 0;
        while (m_cs === 1'b1 && len < bound) begin
            if (m_rdy != 4'b0) begin
                rdy = m_rdy;
                rdy_cycles++;
            end
            if (m_done) done_cyc++;
            if (!m_ldn) ldl++;
            len++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [15:0] w;
        logic [15:0] ww [4];
        logic [3:0]  rdy;
        int len, per, glen, rc, dc, ll, rises, n;
        logic prev;

        ww[0] = 16'hA000; ww[1] = 16'hB111; ww[2] = 16'hC222; ww[3] = 16'hD333;
        rst = 1'b1; enable = 1'b0; valid = '0; word = '0;
        enable2 = 1'b1; valid2 = '0; word2 = '0; sel = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_cs", cs1, 1);
        check("rst_sclk", sclk1, 0);
        check("rst_sdo", sdo1, 0);
        check("rst_ldac", ldn1, 1);
        check("rst_done", done1, 0);
        check("rst_done_id", did1, 0);
        check("rst_busy", busy1, 0);
        rst = 1'b0;
        enable = 1'b1;

        // Single frame from requester 0
        word[15:0] = 16'h1ABC;
        valid = 4'b0001;
        #1;
        check("t1_ready", rdy1, 4'b0001);
        check("t1_busy", busy1, 1);
        @(negedge clk);
        valid = '0;
        capture(w, len, per);
        check("t1_word", w, 16'h1ABC);
        check("t1_cs_len", len, 32);
        check("t1_sclk_period", per, 2);
        check("t1_done", done1, 1);
        check("t1_done_id", did1, 0);
        check("t1_ldac", ldn1, 0);
        gap(10, glen, rdy, rc, dc, ll);
        check("t1_done_cycles", dc, 1);
        check("t1_ldac_cycles", ll, 1);
        check("t1_no_ready", rc, 0);
        check("t1_idle_busy", busy1, 0);

        // All four requesters held valid after a fresh reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        word = {ww[3], ww[2], ww[1], ww[0]};
        valid = 4'hF;
        #1;
        check("t2_first_ready", rdy1, 4'b0001);
        @(negedge clk);
        for (int f = 0; f < 5; f++) begin
            if (f == 4) valid = '0;
            capture(w, len, per);
            check("t2_word", w, ww[f % 4]);
            check("t2_cs_len", len, 32);
            check("t2_done", done1, 1);
            check("t2_done_id", did1, 32'(f % 4));
            gap(20, glen, rdy, rc, dc, ll);
            check("t2_done_cycles", dc, 1);
            check("t2_ldac_cycles", ll, 1);
            if (f < 4) begin
                check("t2_gap", glen, 3);
                check("t2_ready", rdy, 4'b0001 << ((f + 1) % 4));
                check("t2_ready_cycles", rc, 1);
            end else begin
                check("t2_tail_no_ready", rc, 0);
            end
        end

        // Round-robin order with last=0: 2, then 3 ahead of a late 0
        valid = 4'b1100;
        #1;
        check("t3_ready2", rdy1, 4'b0100);
        @(negedge clk);
        valid = 4'b1001;
        capture(w, len, per);
        check("t3_word2", w, ww[2]);
        check("t3_id2", did1, 2);
        gap(20, glen, rdy, rc, dc, ll);
        check("t3_ready3", rdy, 4'b1000);
        valid = 4'b0001;
        capture(w, len, per);
        check("t3_word3", w, ww[3]);
        check("t3_id3", did1, 3);
        gap(20, glen, rdy, rc, dc, ll);
        check("t3_ready0", rdy, 4'b0001);
        valid = '0;
        capture(w, len, per);
        check("t3_id0", did1, 0);
        gap(10, glen, rdy, rc, dc, ll);
        check("t3_idle", rc, 0);

        // Reset at the 7th SCLK rise aborts the frame and restores the pointer
        valid = 4'b0010;
        #1;
        check("t4_ready1", rdy1, 4'b0010);
        @(negedge clk);
        valid = 4'b0101;
        prev = sclk1; rises = 0; n = 0;
        while (rises < 7 && n < 100) begin
            @(negedge clk);
            n++;
            if (sclk1 && !prev) rises++;
            prev = sclk1;
        end
        check("t4_rises", rises, 7);
        rst = 1'b1;
        #1;
        check("t4_cs", cs1, 1);
        check("t4_sclk", sclk1, 0);
        check("t4_done", done1, 0);
        check("t4_ldac", ldn1, 1);
        check("t4_busy", busy1, 0);
        check("t4_ready_in_rst", rdy1, 0);
        @(negedge clk);
        check("t4_done_later", done1, 0);
        rst = 1'b0;
        #1;
        check("t4_ready0", rdy1, 4'b0001);
        @(negedge clk);
        valid = '0;
        capture(w, len, per);
        check("t4_word0", w, ww[0]);
        check("t4_id0", did1, 0);
        gap(10, glen, rdy, rc, dc, ll);

        // Enable dropped at bit 5: frame finishes, no grants until re-enabled
        valid = 4'b0010;
        #1;
        check("t5_ready1", rdy1, 4'b0010);
        @(negedge clk);
        valid = '0;
        prev = sclk1; rises = 0; n = 0;
        while (rises < 5 && n < 100) begin
            @(negedge clk);
            n++;
            if (sclk1 && !prev) rises++;
            prev = sclk1;
        end
        enable = 1'b0;
        valid = 4'b0100;
        capture(w, len, per);
        check("t5_tail_bits", w, 16'h0111);
        check("t5_done", done1, 1);
        check("t5_id", did1, 1);
        check("t5_ldac", ldn1, 0);
        gap(10, glen, rdy, rc, dc, ll);
        check("t5_no_ready", rc, 0);
        check("t5_done_cycles", dc, 1);
        check("t5_busy", busy1, 0);
        enable = 1'b1;
        #1;
        check("t5_resume_ready", rdy1, 4'b0100);
        @(negedge clk);
        valid = '0;
        capture(w, len, per);
        check("t5_resume_word", w, ww[2]);
        check("t5_resume_id", did1, 2);
        gap(10, glen, rdy, rc, dc, ll);

        // CLK_DIV=3, LDAC_EN=0 instance
        sel = 1'b1;
        word2[63:48] = 16'h5A3C;
        valid2 = 4'b1000;
        #1;
        check("t6_ready3", rdy2, 4'b1000);
        @(negedge clk);
        valid2 = '0;
        capture(w, len, per);
        check("t6_word", w, 16'h5A3C);
        check("t6_cs_len", len, 96);
        check("t6_sclk_period", per, 6);
        check("t6_done", done2, 1);
        check("t6_id", did2, 3);
        gap(10, glen, rdy, rc, dc, ll);
        check("t6_done_cycles", dc, 1);
        check("t6_ldac_never_low", ld2_lows, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
